// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Module   : mem_bus_pkg
// Brief    : Shared types and constants for the two-requester line bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 16;
  localparam int LINE_BEATS = 8;

  typedef enum logic [1:0] {
    CMD_NOP        = 2'd0,
    CMD_RESP       = 2'd1,
    CMD_READ_LINE  = 2'd2,
    CMD_WRITE_LINE = 2'd3
  } bus_cmd_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    WR_BEATS  = 3'd2,
    WAIT_RESP = 3'd3,
    RD_BEATS  = 3'd4,
    RELEASE   = 3'd5
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin picker; pointer selects the tie winner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  import mem_bus_pkg::*;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin owner of the memory line bus for two cache requesters;
//            sequences command, write beats, response and read beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int LINE_BEATS = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        M0_C,
  input  logic [ADDR_W-1:0] M0_A,
  input  logic [DATA_W-1:0] M0_D,
  output logic              M0_GNT,
  output logic [1:0]        M0_RC,
  output logic [DATA_W-1:0] M0_RD,
  input  logic [1:0]        M1_C,
  input  logic [ADDR_W-1:0] M1_A,
  input  logic [DATA_W-1:0] M1_D,
  output logic              M1_GNT,
  output logic [1:0]        M1_RC,
  output logic [DATA_W-1:0] M1_RD,
  output logic [1:0]        MEM_C,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [DATA_W-1:0] MEM_D,
  input  logic [1:0]        MEM_RC,
  input  logic [DATA_W-1:0] MEM_RD,
  output logic              ERR
);
  import mem_bus_pkg::*;

  localparam int c_BEAT_W = $clog2(LINE_BEATS);
  localparam int c_TMO_W  = $clog2(TIMEOUT + 1);

  arb_state_e          r_state;
  arb_state_e          w_next;
  logic                r_owner;
  logic                r_ptr;
  bus_cmd_e            r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_BEAT_W-1:0] r_beat;
  logic [c_TMO_W-1:0]  r_tmo;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_busy;
  logic                w_resp;
  logic                w_is_read;
  logic                w_last;
  logic                w_tmo_hit;
  logic [DATA_W-1:0]   w_wdata;
  logic [1:0]          w_rsp_rc;
  logic [DATA_W-1:0]   w_rsp_rd;

  // READ_LINE and WRITE_LINE both have bit 1 set; NOP and reserved do not.
  assign w_req     = {M1_C[1], M0_C[1]};
  assign w_resp    = (MEM_RC == CMD_RESP);
  assign w_is_read = (r_cmd == CMD_READ_LINE);
  assign w_last    = (r_beat == c_BEAT_W'(LINE_BEATS - 1));
  assign w_tmo_hit = (r_tmo == c_TMO_W'(TIMEOUT - 1));
  assign w_wdata   = r_owner ? M1_D : M0_D;

  rr_arb2 u_rr_arb2 (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    MEM_C    = 2'b00;
    MEM_A    = '0;
    MEM_D    = '0;
    ERR      = 1'b0;
    w_rsp_rc = 2'b00;
    w_rsp_rd = '0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_next = CMD;
        end
      end
      CMD: begin
        w_busy = 1'b1;
        MEM_C  = r_cmd;
        MEM_A  = r_addr;
        if (r_cmd == CMD_WRITE_LINE) begin
          MEM_D  = w_wdata;
          w_next = WR_BEATS;
        end else begin
          w_next = WAIT_RESP;
        end
      end
      WR_BEATS: begin
        w_busy = 1'b1;
        MEM_D  = w_wdata;
        if (w_last) begin
          w_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        w_busy = 1'b1;
        // A response landing on the timeout cycle takes priority over the abort.
        if (w_resp) begin
          w_rsp_rc = CMD_RESP;
          if (w_is_read) begin
            w_rsp_rd = MEM_RD;
            w_next   = RD_BEATS;
          end else begin
            w_next   = RELEASE;
          end
        end else if (w_tmo_hit) begin
          ERR    = 1'b1;
          w_next = RELEASE;
        end
      end
      RD_BEATS: begin
        w_busy   = 1'b1;
        w_rsp_rc = MEM_RC;
        w_rsp_rd = MEM_RD;
        if (w_last) begin
          w_next = RELEASE;
        end
      end
      RELEASE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_owner <= 1'b0;
      r_ptr   <= 1'b0;
      r_cmd   <= CMD_NOP;
      r_addr  <= '0;
      r_beat  <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_owner <= w_gnt[1];
            r_cmd   <= bus_cmd_e'(w_gnt[1] ? M1_C : M0_C);
            r_addr  <= w_gnt[0] ? M0_A : M1_A;
          end
        end
        RELEASE: r_ptr <= ~r_owner;
        default: ;
      endcase

      // Beat 0 happens in CMD (write) or on the first response (read).
      if ((r_state == CMD) || ((r_state == WAIT_RESP) && w_resp && w_is_read)) begin
        r_beat <= c_BEAT_W'(1);
      end else if ((r_state == WR_BEATS) || (r_state == RD_BEATS)) begin
        r_beat <= r_beat + 1'b1;
      end else begin
        r_beat <= '0;
      end

      r_tmo <= (r_state == WAIT_RESP) ? r_tmo + 1'b1 : '0;
    end
  end

  assign M0_GNT = w_busy & ~r_owner;
  assign M1_GNT = w_busy &  r_owner;
  assign M0_RC  = r_owner ? 2'b00 : w_rsp_rc;
  assign M1_RC  = r_owner ? w_rsp_rc : 2'b00;
  assign M0_RD  = r_owner ? '0 : w_rsp_rd;
  assign M1_RD  = r_owner ? w_rsp_rd : '0;

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single memory-side line bus (address, command, 16-bit data) between two cache-side requesters, e.g. an I-cache and a D-cache.
- Grants whole line transactions with round-robin fairness.
- Sequences the command, data-beat and response phases, then routes the memory response back to the owning requester only.
- Sits between the caches' memory ports and the memory model; all ports are unidirectional, and tri-state resolution stays outside.

Parameters:
- ADDR_W, 14, line address width (memory-side address bus).
- DATA_W, 16, data bus width per beat.
- LINE_BEATS, 8, beats per line transfer (128-bit line / 16).
- TIMEOUT, 255, maximum cycles in WAIT_RESP before abort; counter width is clog2(TIMEOUT+1).

Ports:
- CLK  in  1  clock; all state on posedge.
- RESET  in  1  asynchronous, active-high reset.
- M0_C  in  2  requester 0 command: 0 NOP, 1 reserved, 2 READ_LINE, 3 WRITE_LINE; held until granted.
- M0_A  in  ADDR_W  requester 0 line address; valid while M0_C is 2 or 3.
- M0_D  in  DATA_W  requester 0 write data beat.
- M0_GNT  out  1  requester 0 owns the bus.
- M0_RC  out  2  response command to requester 0; 1 = RESPONSE, else 0.
- M0_RD  out  DATA_W  response data to requester 0.
- M1_C, M1_A, M1_D, M1_GNT, M1_RC, M1_RD: same as requester 0, for requester 1.
- MEM_C  out  2  command to memory.
- MEM_A  out  ADDR_W  line address to memory.
- MEM_D  out  DATA_W  write data to memory.
- MEM_RC  in  2  memory response command; 1 = RESPONSE.
- MEM_RD  in  DATA_W  memory read data.
- ERR  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; round-robin pointer goes to requester 0; beat and timeout counters clear.
  - All outputs go to 0; an in-flight transaction is dropped without any response.
- States: IDLE, CMD, WR_BEATS, WAIT_RESP, RD_BEATS, RELEASE.
- IDLE:
  - A request is M*_C in {2,3}; values 0 and 1 are ignored.
  - One requester: it wins. Both requesting: the pointer's requester wins.
  - Winner, command and address are registered; GNT goes high next cycle; go to CMD.
- CMD (1 cycle):
  - MEM_C = latched command; MEM_A = latched address.
  - WRITE: MEM_D = winner's M_D combinationally (beat 0); go to WR_BEATS.
  - READ: MEM_D = 0; go to WAIT_RESP.
  - The requester must present write beat 0 in the first cycle its GNT is high.
- WR_BEATS:
  - Beats 1..LINE_BEATS-1, one per cycle; MEM_D = winner's M_D; MEM_C = 0; MEM_A = 0.
  - After the last beat, go to WAIT_RESP.
- WAIT_RESP:
  - Timeout counter increments each cycle.
  - MEM_RC == 1 on a WRITE: forward one cycle of RC = 1 to the winner; go to RELEASE.
  - MEM_RC == 1 on a READ: that cycle is data beat 0; forward RC and RD to the winner combinationally; go to RD_BEATS with count 1.
  - Counter reaches TIMEOUT: pulse ERR; go to RELEASE with no response forwarded.
- RD_BEATS:
  - Forward MEM_RC/MEM_RD to the winner for beats 1..LINE_BEATS-1, unconditionally one per cycle.
  - After the last beat, go to RELEASE.
- RELEASE (1 cycle):
  - GNT goes low; pointer is set to the non-winner; go to IDLE.
  - Consequence: at least one idle bus cycle between transactions, and a requester cannot win twice in a row while the other is requesting.
- Routing:
  - The non-owner's RC/RD are always 0.
  - MEM_RC/MEM_RD arriving outside WAIT_RESP/RD_BEATS are ignored.
- Latency:
  - Request seen in IDLE at cycle t: GNT high and MEM_C driven at t+1.
  - Write data occupies t+1 .. t+LINE_BEATS.
- Simultaneous new request while busy: it waits, held on M_C, with no effect on the current transaction.
- Requester changing M_C/M_A after grant: ignored, since values are latched in IDLE.
- Memory responding in the same cycle the timeout hits: the response wins and no ERR is raised.

Decomposition:
- Package mem_bus_pkg:
  - enum bus_cmd_e {CMD_NOP = 0, CMD_RESP = 1, CMD_READ_LINE = 2, CMD_WRITE_LINE = 3}.
  - constants LINE_BEATS = 8, ADDR_W = 14, DATA_W = 16.
  - enum arb_state_e with the six states above.
- One sub-module, rr_arb2: a two-requester round-robin picker. Inputs: req[1:0], pointer. Output: one-hot grant. Purely combinational; the pointer register stays in the top level.

Test Plan:
- Single read: M0 READ_LINE at A=0x0123 → MEM_C=2 and MEM_A=0x0123 one cycle after the request; memory returns RESP with beats 0x1000..0x1007 → M0 sees RC=1 and the same 8 beats in order; M1_RC/M1_RD stay 0; GNT drops.
- Single write: M1 WRITE_LINE at A=0x3FFF with beats 0xA0..0xA7 → MEM_C=3 with MEM_D=0xA0, then 0xA1..0xA7 on consecutive cycles; memory RESP → M1_RC=1 for exactly one cycle.
- Contention: M0 and M1 both request in the same cycle from reset → M0 served first, then M1; both request again → M0 is served next, alternating with no starvation; at least one idle cycle between grants.
- Timeout: M0 READ with memory silent for 255 cycles → ERR pulses once; M0 receives no RC; a pending M1 request is granted next.
- Reset mid-read: assert RESET during RD_BEATS beat 3 → all outputs 0 immediately (asynchronous); after deassert, the next M1 request is served normally and the pointer is back at M0.
- Noise: MEM_RC=1 while IDLE, and M0_C=1 → no grant and no forwarding; outputs stay 0.
